// File: rtl/rssi_cca_detect_pkg.sv
// Shared state encodings and register-file reset defaults for the RSSI clear-channel-assessment block.
package rssi_cca_detect_pkg;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_BUSY_PEND = 2'd1,
      S_BUSY      = 2'd2,
      S_IDLE_PEND = 2'd3
   } cca_state_t;

   // Reset values for the reg-file copies of threshold/hysteresis/debounce (0.5 dB units).
   localparam int DEF_RSSI_TH       = -164;
   localparam int DEF_RSSI_HYST     = 6;
   localparam int DEF_BUSY_DEBOUNCE = 3;
   localparam int DEF_IDLE_DEBOUNCE = 3;

   function automatic logic is_idle_state(input cca_state_t s);
      return (s == S_IDLE) || (s == S_BUSY_PEND);
   endfunction

endpackage

// File: rtl/rssi_cca_detect_sat_snapshot_cnt.sv
// Saturating event counter with snapshot-and-clear; the event arriving in the snapshot cycle
// seeds the fresh count instead of being lost.
module sat_snapshot_cnt #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             inc,
   input  logic             snapshot,
   output logic [WIDTH-1:0] value,
   output logic             valid
);

   logic [WIDTH-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt   <= '0;
         value <= '0;
         valid <= 1'b0;
      end else begin
         valid <= snapshot;
         if (snapshot) begin
            value <= cnt;
            cnt   <= inc ? WIDTH'(1) : '0;
         end else if (inc && (cnt != {WIDTH{1'b1}})) begin
            cnt <= cnt + WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/rssi_cca_detect.sv
// Clear-channel assessment: RSSI threshold with hysteresis and debounce, TX override, and a
// busy-sample airtime counter.
//
// state        | meaning
// S_IDLE       | channel idle, watching for hi samples
// S_BUSY_PEND  | counting consecutive hi samples, still reported idle
// S_BUSY       | channel busy, watching for lo samples
// S_IDLE_PEND  | counting consecutive lo samples, still reported busy
module rssi_cca_detect
   import rssi_cca_detect_pkg::*;
#(
   parameter int RSSI_HALF_DB_WIDTH = 11,
   parameter int HYST_WIDTH         = 8,
   parameter int DEBOUNCE_WIDTH     = 8,
   parameter int BUSY_CNT_WIDTH     = 32
) (
   input  logic                                 clk,
   input  logic                                 rstn,
   input  logic signed [RSSI_HALF_DB_WIDTH-1:0] rssi_half_db,
   input  logic                                 rssi_half_db_valid,
   input  logic signed [RSSI_HALF_DB_WIDTH-1:0] rssi_th,
   input  logic        [HYST_WIDTH-1:0]         rssi_hyst,
   input  logic        [DEBOUNCE_WIDTH-1:0]     busy_debounce,
   input  logic        [DEBOUNCE_WIDTH-1:0]     idle_debounce,
   input  logic                                 tx_on,
   input  logic                                 busy_cnt_snapshot,
   output logic                                 ch_idle,
   output logic                                 ch_idle_change,
   output logic        [BUSY_CNT_WIDTH-1:0]     busy_sample_cnt,
   output logic                                 busy_sample_cnt_valid
);

   localparam int W  = RSSI_HALF_DB_WIDTH;
   localparam int DW = DEBOUNCE_WIDTH;

   cca_state_t        state, state_nxt;
   logic [DW-1:0]     cnt, cnt_nxt;
   logic [DW:0]       cnt_inc;
   logic signed [W:0] th_low;
   logic signed [W:0] sample_ext;
   logic              hi, lo;
   logic              busy_reach, idle_reach;
   logic              ch_idle_nxt;
   logic              busy_inc;

   // One extra bit keeps th - hyst from wrapping near the most negative threshold.
   assign th_low     = $signed({rssi_th[W-1], rssi_th})
                     - $signed({{(W+1-HYST_WIDTH){1'b0}}, rssi_hyst});
   assign sample_ext = $signed({rssi_half_db[W-1], rssi_half_db});
   assign hi         = rssi_half_db >= rssi_th;
   assign lo         = sample_ext < th_low;

   assign cnt_inc    = {1'b0, cnt} + (DW+1)'(1);
   assign busy_reach = cnt_inc >= {1'b0, busy_debounce};
   assign idle_reach = cnt_inc >= {1'b0, idle_debounce};

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (tx_on) begin
         state_nxt = S_BUSY;
         cnt_nxt   = '0;
      end else if (rssi_half_db_valid) begin
         case (state)
            S_IDLE: begin
               if (hi) begin
                  cnt_nxt   = DW'(1);
                  state_nxt = (busy_debounce <= DW'(1)) ? S_BUSY : S_BUSY_PEND;
               end
            end
            S_BUSY_PEND: begin
               if (hi) begin
                  cnt_nxt = cnt_inc[DW-1:0];
                  if (busy_reach) state_nxt = S_BUSY;
               end else begin
                  cnt_nxt   = '0;
                  state_nxt = S_IDLE;
               end
            end
            S_BUSY: begin
               if (lo) begin
                  cnt_nxt   = DW'(1);
                  state_nxt = (idle_debounce <= DW'(1)) ? S_IDLE : S_IDLE_PEND;
               end
            end
            S_IDLE_PEND: begin
               if (lo) begin
                  cnt_nxt = cnt_inc[DW-1:0];
                  if (idle_reach) state_nxt = S_IDLE;
               end else begin
                  cnt_nxt   = '0;
                  state_nxt = S_BUSY;
               end
            end
            default: begin
               cnt_nxt   = '0;
               state_nxt = S_IDLE;
            end
         endcase
      end
   end

   assign ch_idle_nxt = is_idle_state(state_nxt);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state          <= S_IDLE;
         cnt            <= '0;
         ch_idle        <= 1'b1;
         ch_idle_change <= 1'b0;
      end else begin
         state          <= state_nxt;
         cnt            <= cnt_nxt;
         ch_idle        <= ch_idle_nxt;
         ch_idle_change <= ch_idle_nxt ^ ch_idle;
      end
   end

   // Busy-ness is judged on the flag as it stood when the sample arrived.
   assign busy_inc = rssi_half_db_valid && (!ch_idle || tx_on);

   sat_snapshot_cnt #(
      .WIDTH (BUSY_CNT_WIDTH)
   ) u_busy_cnt (
      .clk      (clk),
      .rstn     (rstn),
      .inc      (busy_inc),
      .snapshot (busy_cnt_snapshot),
      .value    (busy_sample_cnt),
      .valid    (busy_sample_cnt_valid)
   );

endmodule
